// File: rtl/esp_dma64_pkg.sv
// Shared types and widths for the 64-bit DMA memory responder.
// Holds the channel widths, request metadata bundle and FSM states.
package esp_dma64_pkg;

    localparam int DATA_W  = 64;
    localparam int INDEX_W = 32;
    localparam int SIZE_W  = 3;
    localparam int USER_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RD_STREAM,
        WR_STREAM
    } state_t;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [USER_W-1:0] user;
    } req_meta_t;

    // True when a request runs past the end of memory (33-bit sum).
    function automatic logic oob_check(
        input logic [INDEX_W-1:0] idx,
        input logic [INDEX_W-1:0] len,
        input logic [INDEX_W:0]   depth
    );
        return ({1'b0, idx} + {1'b0, len}) > depth;
    endfunction

endpackage

// File: rtl/esp_dma64_ram.sv
// Single-port 64-bit RAM with a one-cycle synchronous read.
// Read data holds its value on write cycles and idle cycles.
module esp_dma64_ram
    import esp_dma64_pkg::*;
#(
    parameter int MEM_WORDS = 65536,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // One access per cycle: write, or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/esp_dma64_mem_responder.sv
// DMA memory responder: streams reads/writes against a local RAM.
// A host port preloads and reads back memory while idle.
module esp_dma64_mem_responder
    import esp_dma64_pkg::*;
#(
    parameter int MEM_WORDS = 65536,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dma_read_ctrl_valid,
    output logic               dma_read_ctrl_ready,
    input  logic [INDEX_W-1:0] dma_read_ctrl_data_index,
    input  logic [INDEX_W-1:0] dma_read_ctrl_data_length,
    input  logic [SIZE_W-1:0]  dma_read_ctrl_data_size,
    input  logic [USER_W-1:0]  dma_read_ctrl_data_user,
    output logic               dma_read_chnl_valid,
    input  logic               dma_read_chnl_ready,
    output logic [DATA_W-1:0]  dma_read_chnl_data,
    input  logic               dma_write_ctrl_valid,
    output logic               dma_write_ctrl_ready,
    input  logic [INDEX_W-1:0] dma_write_ctrl_data_index,
    input  logic [INDEX_W-1:0] dma_write_ctrl_data_length,
    input  logic [SIZE_W-1:0]  dma_write_ctrl_data_size,
    input  logic [USER_W-1:0]  dma_write_ctrl_data_user,
    input  logic               dma_write_chnl_valid,
    output logic               dma_write_chnl_ready,
    input  logic [DATA_W-1:0]  dma_write_chnl_data,
    input  logic               host_en,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata,
    output logic               busy,
    output logic               err_oob
);

    localparam logic [INDEX_W:0] DEPTH = (INDEX_W+1)'(MEM_WORDS);

    state_t state, state_nx;

    logic [INDEX_W-1:0] cnt_left;
    logic [INDEX_W-1:0] iss_left;
    logic [ADDR_W-1:0]  iss_addr;

    logic              out_v, skid_v, pend;
    logic [DATA_W-1:0] out_d, skid_d;

    logic              host_rd_q;
    logic [DATA_W-1:0] host_hold;
    req_meta_t         meta_q;
    logic              err_q;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic               idle, rd_acc, wr_acc, acc;
    logic               pop, wr_open, wr_hs, issue, host_go;
    logic [1:0]         occ;
    logic [INDEX_W-1:0] req_idx, req_len;
    logic               unused_meta;

    assign idle    = (state == IDLE);
    assign rd_acc  = rst && idle && dma_read_ctrl_valid;
    assign wr_acc  = rst && idle && dma_write_ctrl_valid
                     && !dma_read_ctrl_valid;
    assign acc     = rd_acc || wr_acc;
    assign req_idx = rd_acc ? dma_read_ctrl_data_index
                            : dma_write_ctrl_data_index;
    assign req_len = rd_acc ? dma_read_ctrl_data_length
                            : dma_write_ctrl_data_length;

    assign pop     = out_v && dma_read_chnl_ready;
    assign wr_open = rst && (state == WR_STREAM) && (cnt_left != '0);
    assign wr_hs   = wr_open && dma_write_chnl_valid;
    assign host_go = rst && idle && host_en;

    // Prefetch only while the output + skid pair can absorb the word.
    assign occ   = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, pend};
    assign issue = (state == RD_STREAM) && (iss_left != '0)
                   && ((occ - {1'b0, pop}) < 2'd2);

    assign unused_meta = ^meta_q;

    assign dma_read_chnl_valid = out_v;
    assign dma_read_chnl_data  = out_d;
    assign host_rdata = host_rd_q ? ram_rdata : host_hold;
    assign err_oob    = err_q;

    // Single RAM port shared by host, read prefetch and write beats.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = iss_addr;
        ram_wdata = dma_write_chnl_data;
        unique case (1'b1)
            host_go: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
            issue: ram_en = 1'b1;
            wr_hs: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nx             = state;
        dma_read_ctrl_ready  = 1'b0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = wr_open;
        busy                 = !idle;
        unique case (state)
            IDLE: begin
                dma_read_ctrl_ready  = rst;
                dma_write_ctrl_ready = rst && !dma_read_ctrl_valid;
                if (rd_acc) begin
                    state_nx = RD_STREAM;
                end else if (wr_acc) begin
                    state_nx = WR_STREAM;
                end
            end
            RD_STREAM: begin
                if (cnt_left == '0 || (pop && cnt_left == 1)) begin
                    state_nx = IDLE;
                end
            end
            WR_STREAM: begin
                if (cnt_left == '0 || (wr_hs && cnt_left == 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters, read pipeline, host read hold and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_left  <= '0;
            iss_left  <= '0;
            iss_addr  <= '0;
            out_v     <= 1'b0;
            out_d     <= '0;
            skid_v    <= 1'b0;
            skid_d    <= '0;
            pend      <= 1'b0;
            host_rd_q <= 1'b0;
            host_hold <= '0;
            meta_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            pend      <= issue;
            host_rd_q <= host_go && !host_we;
            if (host_rd_q) begin
                host_hold <= ram_rdata;
            end
            if (acc) begin
                cnt_left <= req_len;
                iss_left <= req_len;
                iss_addr <= req_idx[ADDR_W-1:0];
                meta_q   <= rd_acc
                    ? '{dma_read_ctrl_data_size, dma_read_ctrl_data_user}
                    : '{dma_write_ctrl_data_size, dma_write_ctrl_data_user};
                if (oob_check(req_idx, req_len, DEPTH)) begin
                    err_q <= 1'b1;
                end
            end else begin
                if (issue) begin
                    iss_left <= iss_left - 1;
                end
                if (issue || wr_hs) begin
                    iss_addr <= iss_addr + ADDR_W'(1);
                end
                if (pop || wr_hs) begin
                    cnt_left <= cnt_left - 1;
                end
            end
            if (!out_v || pop) begin
                if (skid_v) begin
                    out_v  <= 1'b1;
                    out_d  <= skid_d;
                    skid_v <= pend;
                    if (pend) begin
                        skid_d <= ram_rdata;
                    end
                end else if (pend) begin
                    out_v <= 1'b1;
                    out_d <= ram_rdata;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (pend) begin
                skid_v <= 1'b1;
                skid_d <= ram_rdata;
            end
        end
    end

    esp_dma64_ram #(
        .MEM_WORDS(MEM_WORDS),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
